// File: rtl/hamming_frame_sequencer.sv
// hamming_frame_sequencer
//   Frames a stream of N-bit operand chunks into CC-chunk frames for an external
//   Hamming distance accumulator, captures each frame's final distance, compares
//   it against a threshold and holds the result until it is consumed.
//
// Ports
//   clk                 rising-edge clock
//   rst                 asynchronous reset, active low
//   in_valid/in_ready   upstream chunk handshake
//   x_in, y_in          upstream operand chunks
//   flush               synchronous abort of the partial frame
//   x_acc, y_acc        operands to the accumulator (all-zero when no chunk is accepted)
//   acc_clr             accumulator clear, high for the single CLEAR cycle
//   acc_o               accumulator running sum, including the current chunk
//   thresh              match threshold, sampled when the result is captured
//   res_valid/res_ready downstream result handshake
//   res_dist            captured frame distance
//   res_match           res_dist <= thresh at capture time
module hamming_frame_sequencer #(
  parameter int N  = 50,
  parameter int CC = 32,
  parameter int W  = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] x_in,
  input  logic [N-1:0] y_in,
  input  logic         flush,
  output logic [N-1:0] x_acc,
  output logic [N-1:0] y_acc,
  output logic         acc_clr,
  input  logic [W-1:0] acc_o,
  input  logic [W-1:0] thresh,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_dist,
  output logic         res_match
);

  localparam int CW = (CC > 1) ? $clog2(CC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CC - 1);

  typedef enum logic {COLLECT, CLEAR} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          res_valid_q, res_valid_d;
  logic [W-1:0]  res_dist_q, res_dist_d;
  logic          res_match_q, res_match_d;

  logic cnt_last;
  logic stall;
  logic accept;
  logic capture;

  assign cnt_last = (cnt_q == CNT_LAST);
  // The last chunk of a frame may only enter once the previous result has left
  // (or is leaving this cycle), otherwise its capture would overwrite it.
  assign stall    = cnt_last & res_valid_q & ~res_ready;
  // Gated by rst so nothing is offered as accepted while reset is held.
  assign in_ready = rst & (state_q == COLLECT) & ~flush & ~stall;
  assign accept   = in_valid & in_ready;
  assign capture  = accept & cnt_last;

  // Idle cycles feed an all-zero pair, which contributes nothing to the sum.
  assign x_acc    = accept ? x_in : '0;
  assign y_acc    = accept ? y_in : '0;
  assign acc_clr  = (state_q == CLEAR);

  assign res_valid = res_valid_q;
  assign res_dist  = res_dist_q;
  assign res_match = res_match_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    res_valid_d = res_valid_q;
    res_dist_d  = res_dist_q;
    res_match_d = res_match_q;

    if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end

    case (state_q)
      COLLECT: begin
        if (flush) begin
          cnt_d   = '0;
          state_d = CLEAR;
        end else if (accept) begin
          if (cnt_last) begin
            // acc_o already includes this final chunk.
            res_dist_d  = acc_o;
            res_match_d = (acc_o <= thresh);
            res_valid_d = 1'b1;
            cnt_d       = '0;
            state_d     = CLEAR;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      CLEAR: begin
        state_d = COLLECT;
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= COLLECT;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_dist_q  <= '0;
      res_match_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
      res_dist_q  <= res_dist_d;
      res_match_q <= res_match_d;
    end
  end

  logic unused_capture;
  assign unused_capture = capture;

endmodule

// File: tb/tb_hamming_frame_sequencer.sv
module tb_hamming_frame_sequencer;

  localparam int N  = 50;
  localparam int CC = 32;
  localparam int W  = 11;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] x_in, y_in;
  logic         flush;
  logic [N-1:0] x_acc, y_acc;
  logic         acc_clr;
  logic [W-1:0] acc_o;
  logic [W-1:0] thresh;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_dist;
  logic         res_match;

  hamming_frame_sequencer #(.N(N), .CC(CC), .W(W)) dut (
    .clk       (clk),
    .rst       (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .y_in      (y_in),
    .flush     (flush),
    .x_acc     (x_acc),
    .y_acc     (y_acc),
    .acc_clr   (acc_clr),
    .acc_o     (acc_o),
    .thresh    (thresh),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_dist  (res_dist),
    .res_match (res_match)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural accumulator attached to the DUT's accumulator-side ports.
  logic [W-1:0] acc_sum;
  assign acc_o = acc_sum + W'($countones(x_acc ^ y_acc));
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)       acc_sum <= '0;
    else if (acc_clr) acc_sum <= '0;
    else              acc_sum <= acc_o;
  end

  int total = 0;
  int bad   = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: frame-level view of the sequencer.
  bit m_collect;
  int m_cnt;
  int m_sum;
  bit m_rv;
  int m_rd;
  bit m_rm;
  bit m_acc;
  bit last_ready;

  task automatic model_reset();
    m_collect = 1; m_cnt = 0; m_sum = 0;
    m_rv = 0; m_rd = 0; m_rm = 0; m_acc = 0;
  endtask

  // Drive one cycle (called at posedge+1), compare mid-cycle, advance the model,
  // then return at the next posedge+1.
  task automatic step(input bit iv, input logic [N-1:0] xv, input logic [N-1:0] yv,
                      input bit fl, input bit rr, input logic [W-1:0] th);
    bit exp_ready, acc, cap;
    int d;
    in_valid = iv; x_in = xv; y_in = yv; flush = fl; res_ready = rr; thresh = th;
    #4;
    exp_ready = m_collect && !fl && !(m_cnt == CC-1 && m_rv && !rr);
    acc = iv && exp_ready;
    chk("in_ready",  in_ready,  exp_ready);
    chk("acc_clr",   acc_clr,   !m_collect);
    chk("x_acc",     x_acc,     acc ? xv : '0);
    chk("y_acc",     y_acc,     acc ? yv : '0);
    chk("res_valid", res_valid, m_rv);
    chk("res_dist",  res_dist,  m_rd);
    chk("res_match", res_match, m_rm);
    last_ready = in_ready;
    cap = 0;
    if (!m_collect) begin
      m_collect = 1;
    end else if (fl) begin
      m_cnt = 0; m_sum = 0; m_collect = 0;
    end else if (acc) begin
      d = $countones(xv ^ yv);
      if (m_cnt == CC-1) begin
        cap = 1;
        m_rd = m_sum + d;
        m_rm = (m_rd <= int'(th));
        m_cnt = 0; m_sum = 0; m_collect = 0;
      end else begin
        m_cnt++;
        m_sum += d;
      end
    end
    if (cap) m_rv = 1;
    else if (m_rv && rr) m_rv = 0;
    m_acc = acc;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] rnd_chunk();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[N-1:0];
  endfunction

  function automatic logic [N-1:0] mask_k(int k);
    logic [N-1:0] m;
    int pos;
    m = '0;
    pos = $urandom_range(0, N-k);
    for (int i = 0; i < k; i++) m[pos+i] = 1'b1;
    return m;
  endfunction

  // Offer one chunk until it is accepted, optionally with random idle gaps.
  task automatic send(input logic [N-1:0] xv, input logic [N-1:0] yv, input bit rr,
                      input logic [W-1:0] th, input bit gaps);
    int tries;
    bit iv;
    tries = 0;
    do begin
      iv = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      step(iv, xv, yv, 1'b0, rr, th);
      tries++;
    end while (!m_acc && tries < 300);
    if (!m_acc) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_k(input int k, input bit rr, input logic [W-1:0] th, input bit gaps);
    logic [N-1:0] xv;
    xv = rnd_chunk();
    send(xv, xv ^ mask_k(k), rr, th, gaps);
  endtask

  task automatic async_reset_check();
    in_valid = 1'b1; x_in = rnd_chunk(); y_in = rnd_chunk();
    rst_n = 1'b0;
    #1;
    chk("rst_in_ready",  in_ready,  1'b0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_res_dist",  res_dist,  '0);
    chk("rst_res_match", res_match, 1'b0);
    chk("rst_acc_clr",   acc_clr,   1'b0);
    chk("rst_x_acc",     x_acc,     '0);
    chk("rst_y_acc",     y_acc,     '0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 0; x_in = '0; y_in = '0; flush = 0; res_ready = 0; thresh = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("reset_in_ready",  in_ready,  1'b0);
    chk("reset_res_valid", res_valid, 1'b0);
    chk("reset_res_dist",  res_dist,  '0);
    chk("reset_acc_clr",   acc_clr,   1'b0);
    model_reset();
    rst_n = 1'b1;

    // All-ones vs zero, back to back.
    for (int i = 0; i < CC; i++) send({N{1'b1}}, '0, 1'b0, W'(1599), 1'b0);
    chk("t1_res_valid", res_valid, 1'b1);
    chk("t1_res_dist",  res_dist,  64'd1600);
    chk("t1_res_match", res_match, 1'b0);
    chk("t1_acc_clr",   acc_clr,   1'b1);

    // One differing bit per chunk with random gaps.
    for (int i = 0; i < CC; i++) send_k(1, 1'b1, W'(32), 1'b1);
    chk("t2_res_dist",  res_dist,  64'd32);
    chk("t2_res_match", res_match, 1'b1);
    step(1'b0, rnd_chunk(), rnd_chunk(), 1'b0, 1'b1, W'(32));

    // Held result stalls the last chunk of the next frame.
    for (int i = 0; i < CC; i++) send_k(2, 1'b0, W'(70), 1'b0);
    for (int i = 0; i < CC-1; i++) send_k(3, 1'b0, W'(70), 1'b0);
    step(1'b1, rnd_chunk(), rnd_chunk(), 1'b0, 1'b0, W'(70));
    chk("t3_stall_ready", last_ready, 1'b0);
    chk("t3_held_dist",   res_dist,   64'd64);
    send_k(3, 1'b1, W'(70), 1'b0);
    chk("t3_accept_ready", last_ready, 1'b1);
    chk("t3_new_valid",   res_valid,  1'b1);
    chk("t3_new_dist",    res_dist,   64'd96);
    chk("t3_new_match",   res_match,  1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1, W'(70));

    // Flush at cnt 17, then a clean frame of distance 100.
    for (int i = 0; i < 17; i++) send_k(4, 1'b1, W'(100), 1'b0);
    step(1'b1, rnd_chunk(), rnd_chunk(), 1'b1, 1'b1, W'(100));
    chk("t4_flush_ready", last_ready, 1'b0);
    chk("t4_flush_clr",   acc_clr,    1'b1);
    for (int i = 0; i < CC; i++) send_k((i < 4) ? 4 : 3, 1'b0, W'(100), 1'b0);
    chk("t4_res_dist",  res_dist,  64'd100);
    chk("t4_res_match", res_match, 1'b1);

    // Async reset mid-frame with a pending result.
    for (int i = 0; i < 10; i++) send_k(2, 1'b0, W'(49), 1'b0);
    async_reset_check();
    for (int i = 0; i < CC; i++) send_k((i < 18) ? 2 : 1, 1'b1, W'(49), 1'b0);
    chk("t5_res_dist",  res_dist,  64'd50);
    chk("t5_res_match", res_match, 1'b0);

    // Identical operands, zero threshold.
    for (int i = 0; i < CC; i++) begin
      logic [N-1:0] v;
      v = rnd_chunk();
      send(v, v, 1'b1, W'(0), 1'b1);
    end
    chk("t6_res_dist",  res_dist,  64'd0);
    chk("t6_res_match", res_match, 1'b1);

    // Random soak.
    for (int c = 0; c < 1500; c++) begin
      logic [N-1:0] xv, yv;
      xv = rnd_chunk();
      yv = ($urandom_range(0, 1) == 0) ? (xv ^ mask_k($urandom_range(0, 8))) : rnd_chunk();
      step($urandom_range(0, 9) < 7, xv, yv, $urandom_range(0, 49) == 0,
           $urandom_range(0, 1) == 1, W'($urandom_range(0, 1600)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hamming_frame_sequencer.md
# hamming_frame_sequencer

Frame sequencer wrapped around the 1600-bit / 32-cycle Hamming distance accumulator (N=50 bits per cycle, 11-bit running sum).
- Upstream: accepts 50-bit operand chunks with a valid/ready handshake and forwards them to the accumulator, substituting a neutral chunk on idle cycles.
- Downstream: counts 32 accepted chunks, captures the final distance from the accumulator's `o`, compares it against a threshold and holds the result under a valid/ready handshake.
- Between frames: pulses the accumulator clear so frames are back-to-back without a global reset.

## Interface
- `N`, 50: chunk width in bits.
- `CC`, 32: chunks per frame; must be ≥ 2.
- `W`, 11: distance width; must be ≥ clog2(N*CC+1).

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  chunk available.
- `in_ready`  out  1  chunk accepted this cycle when `in_valid & in_ready`.
- `x_in`, `y_in`  in  N  operand chunks.
- `flush`  in  1  synchronous frame abort; discards the partial frame.
- `x_acc`, `y_acc`  out  N  operands driven to the accumulator `x`, `y`.
- `acc_clr`  out  1  accumulator clear; drives the accumulator reset through integration glue.
- `acc_o`  in  W  accumulator `o`, the combinational running sum including the current chunk.
- `thresh`  in  W  match threshold; sampled at capture.
- `res_valid`  out  1  result held.
- `res_ready`  in  1  result consumed when `res_valid & res_ready`.
- `res_dist`  out  W  captured distance.
- `res_match`  out  1  `res_dist <= thresh`, evaluated at capture.

## Operation
- States:
  - COLLECT: accepting chunks; `cnt` counts 0..CC-1.
  - CLEAR: exactly one cycle.
- Chunk path:
  - `accept = in_valid & in_ready`.
  - `x_acc`/`y_acc` equal `x_in`/`y_in` when `accept`, else all zeros. The all-zero neutral chunk adds 0 to the sum.
- COLLECT:
  - `in_ready = 1`, except when `cnt == CC-1` and `res_valid & ~res_ready` (result-stall).
  - On accept with `cnt < CC-1`: `cnt++`.
  - On accept with `cnt == CC-1`:
    - capture `res_dist <= acc_o` and `res_match <= (acc_o <= thresh)`, unsigned;
    - set `res_valid`;
    - `cnt <= 0`;
    - go to CLEAR.
- CLEAR: `acc_clr = 1`, `in_ready = 0`, then return to COLLECT.
- `flush` (in COLLECT, highest priority):
  - `in_ready = 0` that cycle, so no accept;
  - `cnt <= 0`, go to CLEAR;
  - the held result is untouched.
- `flush` in CLEAR has no effect.
- Result register:
  - `res_valid` clears on `res_valid & res_ready` unless a capture happens the same cycle; the capture wins and loads the new result.
  - `res_dist` and `res_match` are stable while `res_valid & ~res_ready`.

## Timing
- Reset (`rst` low, async):
  - state COLLECT, `cnt = 0`;
  - `res_valid = 0`, `res_dist = 0`, `res_match = 0`, `acc_clr = 0`;
  - `in_ready = 0` while `rst` is low;
  - `x_acc = y_acc = 0`.
- Reset in mid-frame discards the partial frame and any pending result. The accumulator is reset by the same global reset.
- Latency:
  - `res_valid` rises on the edge that accepts the CC-th chunk.
  - `acc_clr` is high for the following cycle.
  - The first chunk of the next frame can be accepted the cycle after CLEAR.
  - Frame period minimum is CC+1 cycles.
- `acc_clr`, `in_ready`, `x_acc` and `y_acc` are combinational from state/count and inputs. `res_*` outputs are registered.
- `in_valid` gaps are allowed at any count; neutral chunks are inserted during gaps.

## Test plan
- 32 back-to-back chunks `x_in = all-ones`, `y_in = 0`, `thresh = 1599` → `res_valid` on the 32nd accept edge, `res_dist = 1600`, `res_match = 0`, `acc_clr` high for the next cycle.
- 32 chunks with exactly 1 differing bit each, random `in_valid` gaps, `thresh = 32` → `res_dist = 32`, `res_match = 1`. Gap cycles show `x_acc = y_acc = 0`.
- Frame 1 result held with `res_ready = 0` through frame 2's 31st chunk → `in_ready = 0` at `cnt = 31`. Raising `res_ready` the same cycle lets chunk 32 be accepted, and frame 2's result replaces frame 1's.
- `flush` at `cnt = 17` → no accept that cycle, one CLEAR cycle, then a full 32-chunk frame of distance 100 reports `res_dist = 100`, with no residue from the flushed chunks.
- Async reset asserted mid-frame with `res_valid = 1` → all outputs reach reset values immediately. After release, the first frame reports the correct distance.
- Identical operands for 32 chunks, `thresh = 0` → `res_dist = 0`, `res_match = 1`.
